// File: rtl/im_fetch_unit.sv
// Byte-organised instruction store with a program-load port and a valid/ready
// fetch path. Fetched words pass through a small response FIFO.
module im_fetch_unit #(
  parameter int MEM_BYTES  = 128,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int RSP_DEPTH  = 2,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start_i,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [7:0]    load_data_i,
  input  logic          load_done_i,
  output logic          load_mode_o,
  output logic          load_ovf_o,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [31:0]   req_addr_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_instr_o,
  output logic [1:0]    rsp_err_o
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DRAIN} state_e;

  state_e          state_q;
  logic            loadMode_q;
  logic            loadOvf_q;
  logic            inflight_q;
  logic [31:0]     inflInstr_q;
  logic [1:0]      inflErr_q;
  logic [31:0]     fifoInstr_q [RSP_DEPTH];
  logic [1:0]      fifoErr_q   [RSP_DEPTH];
  logic [PW-1:0]   rdPtr_q, wrPtr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      mem_q [MEM_BYTES];

  logic            accept, pop, push;
  logic [CW:0]     occupancy;
  logic [AW-1:0]   wordBase;
  logic [31:0]     readWord, fetchInstr;
  logic [1:0]      fetchErr;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The store is deliberately left out of reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && load_we_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  assign pop         = rsp_valid_o & rsp_ready_i;
  assign push        = inflight_q;
  assign accept      = req_valid_i & req_ready_o;
  assign occupancy   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign req_ready_o = (state_q == ST_RUN) && !load_start_i &&
                       (occupancy < (CW+1)'(RSP_DEPTH));

  always_comb begin
    wordBase = {req_addr_i[AW-1:2], 2'b00};
    readWord = BIG_ENDIAN ?
      {mem_q[wordBase], mem_q[wordBase | AW'(1)], mem_q[wordBase | AW'(2)], mem_q[wordBase | AW'(3)]} :
      {mem_q[wordBase | AW'(3)], mem_q[wordBase | AW'(2)], mem_q[wordBase | AW'(1)], mem_q[wordBase]};
    fetchErr = 2'b00;
    if (req_addr_i[1:0] != 2'b00) begin
      fetchErr = 2'b01;
    end else if (req_addr_i > 32'(MEM_BYTES - 4)) begin
      fetchErr = 2'b10;
    end
    fetchInstr = (fetchErr == 2'b00) ? readWord : 32'h0;
  end

  // Mode FSM, the in-flight stage and the response FIFO share one register block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      loadMode_q  <= 1'b1;
      loadOvf_q   <= 1'b0;
      inflight_q  <= 1'b0;
      inflInstr_q <= 32'h0;
      inflErr_q   <= 2'b00;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifoInstr_q[i] <= 32'h0;
        fifoErr_q[i]   <= 2'b00;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_done_i) begin
            state_q    <= ST_RUN;
            loadMode_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (load_we_i) loadOvf_q <= 1'b1;
          if (load_start_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (load_we_i) loadOvf_q <= 1'b1;
          if (count_q == '0 && !inflight_q) begin
            state_q    <= ST_LOAD;
            loadMode_q <= 1'b1;
            loadOvf_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_LOAD;
          loadMode_q <= 1'b1;
        end
      endcase

      inflight_q <= accept;
      if (accept) begin
        inflInstr_q <= fetchInstr;
        inflErr_q   <= fetchErr;
      end

      // Acceptance already reserved a slot, so a push never finds the FIFO full.
      if (push) begin
        fifoInstr_q[wrPtr_q] <= inflInstr_q;
        fifoErr_q[wrPtr_q]   <= inflErr_q;
        wrPtr_q              <= nextPtr(wrPtr_q);
      end
      if (pop) rdPtr_q <= nextPtr(rdPtr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign load_mode_o = loadMode_q;
  assign load_ovf_o  = loadOvf_q;
  assign rsp_valid_o = (count_q != '0);
  assign rsp_instr_o = fifoInstr_q[rdPtr_q];
  assign rsp_err_o   = fifoErr_q[rdPtr_q];

endmodule

// File: tb/tb_im_fetch_unit.sv
// Directed bench for im_fetch_unit: big- and little-endian instances run in
// lock-step while a scoreboard queue checks every delivered response.
module tb_im_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        loadStart, loadWe, loadDone;
  logic [6:0]  loadAddr;
  logic [7:0]  loadData;
  logic        reqValid, rspReady;
  logic [31:0] reqAddr;

  logic        loadMode, loadOvf, reqReady, rspValid;
  logic [31:0] rspInstr;
  logic [1:0]  rspErr;
  logic        leLoadMode, leLoadOvf, leReqReady, leRspValid;
  logic [31:0] leRspInstr;
  logic [1:0]  leRspErr;

  int total = 0;
  int bad   = 0;
  logic [7:0]  modelMem [128];
  logic [33:0] sbQ [$];

  im_fetch_unit #(.MEM_BYTES(128), .BIG_ENDIAN(1'b1), .RSP_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start_i(loadStart), .load_we_i(loadWe), .load_addr_i(loadAddr),
    .load_data_i(loadData), .load_done_i(loadDone),
    .load_mode_o(loadMode), .load_ovf_o(loadOvf),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_addr_i(reqAddr),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
    .rsp_instr_o(rspInstr), .rsp_err_o(rspErr)
  );

  im_fetch_unit #(.MEM_BYTES(128), .BIG_ENDIAN(1'b0), .RSP_DEPTH(2)) dutLe (
    .clk(clk), .rst_n(rst_n),
    .load_start_i(loadStart), .load_we_i(loadWe), .load_addr_i(loadAddr),
    .load_data_i(loadData), .load_done_i(loadDone),
    .load_mode_o(leLoadMode), .load_ovf_o(leLoadOvf),
    .req_valid_i(reqValid), .req_ready_o(leReqReady), .req_addr_i(reqAddr),
    .rsp_valid_o(leRspValid), .rsp_ready_i(rspReady),
    .rsp_instr_o(leRspInstr), .rsp_err_o(leRspErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Expected {err, instr} for a fetch, from the bench's own copy of the image.
  function automatic logic [33:0] expectFor(input logic [31:0] a);
    int idx;
    idx = int'(a[6:0]);
    if (a[1:0] != 2'b00) return {2'b01, 32'h0};
    if (a > 32'd124) return {2'b10, 32'h0};
    return {2'b00, modelMem[idx], modelMem[idx+1], modelMem[idx+2], modelMem[idx+3]};
  endfunction

  // Scoreboard: push on acceptance, pop and compare on delivery.
  always @(negedge clk) begin
    logic [33:0] entry;
    logic [31:0] leExp;
    if (rst_n) begin
      if (rspValid && rspReady) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedRsp", 64'(rspInstr), 64'hDEAD_DEAD);
        end else begin
          entry = sbQ.pop_front();
          leExp = {entry[7:0], entry[15:8], entry[23:16], entry[31:24]};
          checkOutput("rspInstr", 64'(rspInstr), 64'(entry[31:0]));
          checkOutput("rspErr", 64'(rspErr), 64'(entry[33:32]));
          checkOutput("leRspInstr", 64'(leRspInstr), 64'(leExp));
        end
      end
      if (reqValid && reqReady) sbQ.push_back(expectFor(reqAddr));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadByte(input int a, input logic [7:0] d);
    loadWe = 1'b1; loadAddr = 7'(a); loadData = d;
    modelMem[a] = d;
    tick();
    loadWe = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] a);
    bit accepted;
    accepted = 1'b0;
    reqValid = 1'b1; reqAddr = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (reqReady) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    if (!accepted) checkOutput("acceptTimeout", 64'(accepted), 64'd1);
  endtask

  task automatic fetchOne(input logic [31:0] a, input logic [31:0] expInstr, input logic [1:0] expErr);
    applyStimulus(a);
    tick();
    checkOutput("fetchValid", 64'(rspValid), 64'd1);
    checkOutput("fetchInstr", 64'(rspInstr), 64'(expInstr));
    checkOutput("fetchErr", 64'(rspErr), 64'(expErr));
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40; i++) begin
      if (sbQ.size() == 0 && !rspValid) break;
      tick();
    end
    checkOutput("drainEmpty", 64'(sbQ.size()), 64'd0);
  endtask

  task automatic enterRun();
    loadDone = 1'b1;
    tick();
    loadDone = 1'b0;
    checkOutput("runMode", 64'(loadMode), 64'd0);
  endtask

  initial begin
    logic [31:0] addrs [4];
    int acceptedCnt;
    int idx;
    rst_n = 1'b0; loadStart = 1'b0; loadWe = 1'b0; loadDone = 1'b0;
    loadAddr = '0; loadData = '0; reqValid = 1'b0; reqAddr = '0; rspReady = 1'b0;
    repeat (3) tick();
    checkOutput("rstLoadMode", 64'(loadMode), 64'd1);
    checkOutput("rstOvf", 64'(loadOvf), 64'd0);
    checkOutput("rstRspValid", 64'(rspValid), 64'd0);
    checkOutput("rstReqReady", 64'(reqReady), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] loading image");
    for (int i = 0; i < 128; i++) begin
      loadByte(i, (i < 8) ? 8'(i * 8'h11) : 8'((i * 7 + 3) & 8'hFF));
    end
    enterRun();

    $display("[TB] back-to-back fetch");
    rspReady = 1'b1;
    reqValid = 1'b1; reqAddr = 32'h0;
    checkOutput("readyRun", 64'(reqReady), 64'd1);
    tick();
    reqAddr = 32'h4;
    checkOutput("readyB2b", 64'(reqReady), 64'd1);
    checkOutput("notYetValid", 64'(rspValid), 64'd0);
    tick();
    reqValid = 1'b0;
    checkOutput("b2bValid0", 64'(rspValid), 64'd1);
    checkOutput("b2bInstr0", 64'(rspInstr), 64'h00112233);
    checkOutput("leInstr0", 64'(leRspInstr), 64'h33221100);
    checkOutput("b2bErr0", 64'(rspErr), 64'd0);
    tick();
    checkOutput("b2bValid1", 64'(rspValid), 64'd1);
    checkOutput("b2bInstr1", 64'(rspInstr), 64'h44556677);
    tick();
    checkOutput("b2bEmpty", 64'(rspValid), 64'd0);

    $display("[TB] error codes and range edge");
    fetchOne(32'h2, 32'h0, 2'b01);
    fetchOne(32'h7C, 32'h676E757C, 2'b00);
    fetchOne(32'h80, 32'h0, 2'b10);
    fetchOne(32'hFFFF_FFFC, 32'h0, 2'b10);
    fetchOne(32'hFFFF_FFFF, 32'h0, 2'b01);
    waitDrain();

    $display("[TB] backpressure");
    rspReady = 1'b0;
    addrs = '{32'h8, 32'hC, 32'h10, 32'h14};
    acceptedCnt = 0; idx = 0;
    reqValid = 1'b1; reqAddr = addrs[0];
    repeat (8) begin
      @(negedge clk);
      if (reqReady) begin
        acceptedCnt++;
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < 4) reqAddr = addrs[idx];
    end
    reqValid = 1'b0;
    checkOutput("fullAccepted", 64'(acceptedCnt), 64'd2);
    checkOutput("fullReqReady", 64'(reqReady), 64'd0);
    checkOutput("fullRspValid", 64'(rspValid), 64'd1);
    checkOutput("fullHead", 64'(rspInstr), 64'(expectFor(32'h8)));
    rspReady = 1'b1;
    for (int i = idx; i < 4; i++) applyStimulus(addrs[i]);
    waitDrain();

    $display("[TB] drain to load");
    rspReady = 1'b0;
    applyStimulus(32'h0);
    applyStimulus(32'h4);
    tick();
    loadStart = 1'b1; reqValid = 1'b1; reqAddr = 32'h8;
    checkOutput("drainReqReady", 64'(reqReady), 64'd0);
    tick();
    loadStart = 1'b0; reqValid = 1'b0;
    loadWe = 1'b1; loadAddr = 7'd0; loadData = 8'hAA;
    tick();
    loadWe = 1'b0;
    checkOutput("drainOvf", 64'(loadOvf), 64'd1);
    checkOutput("drainMode", 64'(loadMode), 64'd0);
    rspReady = 1'b1;
    waitDrain();
    for (int i = 0; i < 10; i++) begin
      if (loadMode) break;
      tick();
    end
    checkOutput("backToLoad", 64'(loadMode), 64'd1);
    checkOutput("ovfCleared", 64'(loadOvf), 64'd0);
    enterRun();
    fetchOne(32'h0, 32'h00112233, 2'b00);
    waitDrain();

    $display("[TB] async reset mid-fetch");
    rspReady = 1'b0;
    applyStimulus(32'h4);
    tick();
    checkOutput("preRstValid", 64'(rspValid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstDropValid", 64'(rspValid), 64'd0);
    checkOutput("rstMode", 64'(loadMode), 64'd1);
    sbQ.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("postRstMode", 64'(loadMode), 64'd1);
    checkOutput("postRstReady", 64'(reqReady), 64'd0);
    checkOutput("postRstValid", 64'(rspValid), 64'd0);
    enterRun();
    rspReady = 1'b1;
    fetchOne(32'h0, 32'h00112233, 2'b00);
    fetchOne(32'h4, 32'h44556677, 2'b00);
    fetchOne(32'h7C, 32'h676E757C, 2'b00);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
